// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   ZERO_REG  : index of the hardwired-zero register
//   addrWidth : clog2-style width of a register index (minimum 1 bit)
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int ZERO_REG = 0;

    // Smallest width w such that 2**w >= n. Written as a bounded loop so it
    // can be evaluated at elaboration time by any tool.
    function automatic int addrWidth(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
// Bundles the read, writeback and reserve ports of regfile_mp.
//   rd_addr  : NRD read addresses, port k at [k*AW +: AW]
//   rd_data  : NRD read data words, port k at [k*XLEN +: XLEN]
//   rd_busy  : per read port, register has an outstanding reservation
//   wr_en    : per write port enable
//   wr_addr  : NWR write addresses
//   wr_data  : NWR write data words
//   rsv_en   : reserve a destination register
//   rsv_addr : register to reserve
// master = decode/issue + writeback side, slave = the register file.
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    import regfile_pkg::*;

    localparam int AW = addrWidth(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_bypass_mux.sv
// ---------------------------------------------------------------------------
// regfile_bypass_mux
// Output selection for one read port of regfile_mp.
//   rdAddr_i     : register index being read
//   storedData_i : registered contents of that register
//   storedBusy_i : registered busy bit of that register
//   wrEn_i/wrAddr_i/wrData_i : all writeback ports (same-cycle writes)
//   rdData_o/rdBusy_o : value and busy flag presented on the read port
// ---------------------------------------------------------------------------
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]       rdAddr_i,
    input  logic [XLEN-1:0]     storedData_i,
    input  logic                storedBusy_i,
    input  logic [NWR-1:0]      wrEn_i,
    input  logic [NWR*AW-1:0]   wrAddr_i,
    input  logic [NWR*XLEN-1:0] wrData_i,
    output logic [XLEN-1:0]     rdData_o,
    output logic                rdBusy_o
);

    if (BYPASS != 0) begin : gBypass
        // Forward any same-cycle write to this address. Ports are scanned in
        // ascending order so the highest-index match is the one that sticks,
        // matching the write priority of the array. A forwarded value is the
        // result the reservation was waiting for, so busy is dropped.
        // Register 0 overrides everything last.
        always_comb begin
            rdData_o = storedData_i;
            rdBusy_o = storedBusy_i;
            for (int j = 0; j < NWR; j++) begin
                if (wrEn_i[j] && (wrAddr_i[j*AW +: AW] == rdAddr_i)) begin
                    rdData_o = wrData_i[j*XLEN +: XLEN];
                    rdBusy_o = 1'b0;
                end
            end
            if (rdAddr_i == AW'(ZERO_REG)) begin
                rdData_o = '0;
                rdBusy_o = 1'b0;
            end
        end
    end else begin : gNoBypass
        // Registered state only; same-cycle writes show up next cycle.
        logic unusedWrite;
        assign unusedWrite = ^{wrEn_i, wrAddr_i, wrData_i};

        always_comb begin
            rdData_o = storedData_i;
            rdBusy_o = storedBusy_i;
            if (rdAddr_i == AW'(ZERO_REG)) begin
                rdData_o = '0;
                rdBusy_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with a per-register busy scoreboard.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears data and busy bits
//   bus   : regfile_mp_if slave (NRD read ports, NWR write ports, reserve)
// Register 0 is hardwired zero and never busy.
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int AW = addrWidth(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next-state for the array and scoreboard. Writes are applied in port
    // order so the highest-index port wins a same-address collision; the
    // reservation is applied after all writes so it beats a same-cycle
    // completion to the same register (a new producer has been issued).
    // Address 0 is filtered on both paths so mem_q[0]/busy_q[0] stay zero.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
                mem_d[bus.wr_addr[j*AW +: AW]]  = bus.wr_data[j*XLEN +: XLEN];
                busy_d[bus.wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus.rsv_en && (bus.rsv_addr != AW'(ZERO_REG))) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
    end

    // State register. Reset is asynchronous, so anything presented on the
    // write or reserve ports while rst_n is low is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // One output mux per read port; reads are purely combinational.
    for (genvar k = 0; k < NRD; k++) begin : gRead
        logic [AW-1:0]   rdAddr;
        logic [XLEN-1:0] rdData;
        logic            rdBusy;

        assign rdAddr = bus.rd_addr[k*AW +: AW];

        regfile_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) uMux (
            .rdAddr_i     (rdAddr),
            .storedData_i (mem_q[rdAddr]),
            .storedBusy_i (busy_q[rdAddr]),
            .wrEn_i       (bus.wr_en),
            .wrAddr_i     (bus.wr_addr),
            .wrData_i     (bus.wr_data),
            .rdData_o     (rdData),
            .rdBusy_o     (rdBusy)
        );

        assign bus.rd_data[k*XLEN +: XLEN] = rdData;
        assign bus.rd_busy[k]              = rdBusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp. Three instances share clk/rst_n:
//   dutA : default sizes, BYPASS = 1
//   dutB : default sizes, BYPASS = 0
//   dutC : XLEN = 64, NREG = 16, NRD = 3, NWR = 1, BYPASS = 1
// Expected read results are queued when stimulus is applied and popped
// when the combinational read outputs are sampled.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) busA ();
    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) busB ();
    regfile_mp_if #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) busC ();

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1))
        dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0))
        dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1), .BYPASS(1))
        dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

    typedef struct {
        logic [63:0] data;
        logic        busy;
        string       tag;
    } expT;

    expT expQ[$];
    expT ex;
    int  assertCount = 0;
    int  failCount   = 0;

    // Park every input of every instance.
    task automatic driveIdle();
        busA.wr_en = '0; busA.wr_addr = '0; busA.wr_data = '0;
        busA.rsv_en = 1'b0; busA.rsv_addr = '0; busA.rd_addr = '0;
        busB.wr_en = '0; busB.wr_addr = '0; busB.wr_data = '0;
        busB.rsv_en = 1'b0; busB.rsv_addr = '0; busB.rd_addr = '0;
        busC.wr_en = '0; busC.wr_addr = '0; busC.wr_data = '0;
        busC.rsv_en = 1'b0; busC.rsv_addr = '0; busC.rd_addr = '0;
    endtask

    // Power-on reset: every read port shows zero and not busy.
    task automatic test_reset();
        rst_n = 1'b0;
        driveIdle();
        busA.rd_addr = {5'd31, 5'd1};
        expQ.push_back('{64'h0, 1'b0, "reset_a_p0"});
        expQ.push_back('{64'h0, 1'b0, "reset_a_p1"});
        #1;
        for (int k = 0; k < 2; k++) begin
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[k*32 +: 32] !== ex.data[31:0] || busA.rd_busy[k] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[k*32 +: 32], busA.rd_busy[k], ex.data[31:0], ex.busy);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset asserted mid-run clears data and busy immediately and blocks
    // a write presented while it is held.
    task automatic test_reset_midrun();
        @(negedge clk);
        driveIdle();
        busA.wr_en = 2'b01; busA.wr_addr[4:0] = 5'd5; busA.wr_data[31:0] = 32'hDEADBEEF;
        busA.rsv_en = 1'b1; busA.rsv_addr = 5'd6;
        @(negedge clk);
        driveIdle();
        busA.rd_addr = {5'd6, 5'd5};
        expQ.push_back('{64'hDEADBEEF, 1'b0, "pre_reset_x5"});
        expQ.push_back('{64'h0, 1'b1, "pre_reset_x6"});
        #1;
        for (int k = 0; k < 2; k++) begin
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[k*32 +: 32] !== ex.data[31:0] || busA.rd_busy[k] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[k*32 +: 32], busA.rd_busy[k], ex.data[31:0], ex.busy);
            end
        end
        #1;
        rst_n = 1'b0;
        expQ.push_back('{64'h0, 1'b0, "async_reset_x5"});
        expQ.push_back('{64'h0, 1'b0, "async_reset_x6"});
        #1;
        for (int k = 0; k < 2; k++) begin
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[k*32 +: 32] !== ex.data[31:0] || busA.rd_busy[k] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[k*32 +: 32], busA.rd_busy[k], ex.data[31:0], ex.busy);
            end
        end
        // A write presented across a clock edge while reset is still low
        busA.wr_en = 2'b01; busA.wr_addr[4:0] = 5'd5; busA.wr_data[31:0] = 32'h00000055;
        @(posedge clk);
        #1;
        driveIdle();
        busA.rd_addr = {5'd6, 5'd5};
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back('{64'h0, 1'b0, "write_during_reset_x5"});
        #1;
        ex = expQ.pop_front();
        assertCount++;
        if (busA.rd_data[31:0] !== ex.data[31:0] || busA.rd_busy[0] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busA.rd_data[31:0], busA.rd_busy[0], ex.data[31:0], ex.busy);
        end
    endtask

    // Write x3 on port 0: visible same cycle with bypass, next cycle without.
    task automatic test_write_read();
        @(negedge clk);
        driveIdle();
        busA.wr_en = 2'b01; busA.wr_addr[4:0] = 5'd3; busA.wr_data[31:0] = 32'h12345678;
        busA.rd_addr[4:0] = 5'd3;
        busB.wr_en = 2'b01; busB.wr_addr[4:0] = 5'd3; busB.wr_data[31:0] = 32'h12345678;
        busB.rd_addr[4:0] = 5'd3;
        expQ.push_back('{64'h12345678, 1'b0, "bypass_same_cycle"});
        expQ.push_back('{64'h0, 1'b0, "nobypass_same_cycle"});
        #1;
        ex = expQ.pop_front();
        assertCount++;
        if (busA.rd_data[31:0] !== ex.data[31:0] || busA.rd_busy[0] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busA.rd_data[31:0], busA.rd_busy[0], ex.data[31:0], ex.busy);
        end
        ex = expQ.pop_front();
        assertCount++;
        if (busB.rd_data[31:0] !== ex.data[31:0] || busB.rd_busy[0] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busB.rd_data[31:0], busB.rd_busy[0], ex.data[31:0], ex.busy);
        end
        @(negedge clk);
        driveIdle();
        busA.rd_addr = {5'd3, 5'd3};
        busB.rd_addr[4:0] = 5'd3;
        expQ.push_back('{64'h12345678, 1'b0, "bypass_next_cycle_p1"});
        expQ.push_back('{64'h12345678, 1'b0, "nobypass_next_cycle"});
        #1;
        ex = expQ.pop_front();
        assertCount++;
        if (busA.rd_data[63:32] !== ex.data[31:0] || busA.rd_busy[1] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busA.rd_data[63:32], busA.rd_busy[1], ex.data[31:0], ex.busy);
        end
        ex = expQ.pop_front();
        assertCount++;
        if (busB.rd_data[31:0] !== ex.data[31:0] || busB.rd_busy[0] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busB.rd_data[31:0], busB.rd_busy[0], ex.data[31:0], ex.busy);
        end
    endtask

    // Both write ports hit x7 in the same cycle; port 1 must win.
    task automatic test_collision();
        @(negedge clk);
        driveIdle();
        busA.wr_en = 2'b11; busA.wr_addr = {5'd7, 5'd7};
        busA.wr_data = {32'h00002222, 32'h00001111};
        busA.rd_addr = {5'd7, 5'd7};
        busB.wr_en = 2'b11; busB.wr_addr = {5'd7, 5'd7};
        busB.wr_data = {32'h00002222, 32'h00001111};
        expQ.push_back('{64'h2222, 1'b0, "collision_bypass_p0"});
        expQ.push_back('{64'h2222, 1'b0, "collision_bypass_p1"});
        #1;
        for (int k = 0; k < 2; k++) begin
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[k*32 +: 32] !== ex.data[31:0] || busA.rd_busy[k] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[k*32 +: 32], busA.rd_busy[k], ex.data[31:0], ex.busy);
            end
        end
        @(negedge clk);
        driveIdle();
        busA.rd_addr[4:0] = 5'd7;
        busB.rd_addr[4:0] = 5'd7;
        expQ.push_back('{64'h2222, 1'b0, "collision_stored_a"});
        expQ.push_back('{64'h2222, 1'b0, "collision_stored_b"});
        #1;
        ex = expQ.pop_front();
        assertCount++;
        if (busA.rd_data[31:0] !== ex.data[31:0] || busA.rd_busy[0] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busA.rd_data[31:0], busA.rd_busy[0], ex.data[31:0], ex.busy);
        end
        ex = expQ.pop_front();
        assertCount++;
        if (busB.rd_data[31:0] !== ex.data[31:0] || busB.rd_busy[0] !== ex.busy) begin
            failCount++;
            $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     ex.tag, busB.rd_data[31:0], busB.rd_busy[0], ex.data[31:0], ex.busy);
        end
    endtask

    // Writes and reservations aimed at x0 have no visible effect.
    task automatic test_zero_reg();
        @(negedge clk);
        driveIdle();
        busA.wr_en = 2'b11; busA.wr_addr = '0; busA.wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
        busA.rsv_en = 1'b1; busA.rsv_addr = 5'd0;
        busA.rd_addr = '0;
        expQ.push_back('{64'h0, 1'b0, "zero_same_cycle_p0"});
        expQ.push_back('{64'h0, 1'b0, "zero_same_cycle_p1"});
        #1;
        for (int k = 0; k < 2; k++) begin
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[k*32 +: 32] !== ex.data[31:0] || busA.rd_busy[k] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[k*32 +: 32], busA.rd_busy[k], ex.data[31:0], ex.busy);
            end
        end
        @(negedge clk);
        driveIdle();
        expQ.push_back('{64'h0, 1'b0, "zero_next_cycle_p0"});
        expQ.push_back('{64'h0, 1'b0, "zero_next_cycle_p1"});
        #1;
        for (int k = 0; k < 2; k++) begin
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[k*32 +: 32] !== ex.data[31:0] || busA.rd_busy[k] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[k*32 +: 32], busA.rd_busy[k], ex.data[31:0], ex.busy);
            end
        end
    endtask

    // Busy scoreboard: reserve, complete, and reserve+complete together.
    // Each step lists {A port0 addr, B port0 addr} stimulus and expectations.
    task automatic test_scoreboard();
        for (int step = 0; step < 6; step++) begin
            @(negedge clk);
            driveIdle();
            busA.rd_addr = {5'd9, 5'd9};
            busB.rd_addr[4:0] = 5'd4;
            case (step)
                0: begin
                    busA.rsv_en = 1'b1; busA.rsv_addr = 5'd9;
                    busB.rsv_en = 1'b1; busB.rsv_addr = 5'd4;
                    expQ.push_back('{64'h0, 1'b0, "rsv_not_yet_visible_a"});
                    expQ.push_back('{64'h0, 1'b0, "rsv_not_yet_visible_b"});
                end
                1: begin
                    busB.wr_en = 2'b01; busB.wr_addr[4:0] = 5'd4; busB.wr_data[31:0] = 32'h00004444;
                    expQ.push_back('{64'h0, 1'b1, "rsv_visible_a"});
                    expQ.push_back('{64'h0, 1'b1, "nobypass_busy_held"});
                end
                2: begin
                    busA.wr_en = 2'b01; busA.wr_addr[4:0] = 5'd9; busA.wr_data[31:0] = 32'h0000ABCD;
                    expQ.push_back('{64'hABCD, 1'b0, "bypass_clears_busy"});
                    expQ.push_back('{64'h4444, 1'b0, "nobypass_busy_cleared"});
                end
                3: begin
                    expQ.push_back('{64'hABCD, 1'b0, "write_cleared_busy"});
                    expQ.push_back('{64'h4444, 1'b0, "nobypass_stable"});
                end
                4: begin
                    busA.rsv_en = 1'b1; busA.rsv_addr = 5'd9;
                    busA.wr_en = 2'b10; busA.wr_addr[9:5] = 5'd9; busA.wr_data[63:32] = 32'h00005A5A;
                    expQ.push_back('{64'h5A5A, 1'b0, "rsv_write_bypass"});
                    expQ.push_back('{64'h4444, 1'b0, "nobypass_idle"});
                end
                default: begin
                    expQ.push_back('{64'h5A5A, 1'b1, "rsv_beats_write"});
                    expQ.push_back('{64'h4444, 1'b0, "nobypass_idle2"});
                end
            endcase
            #1;
            ex = expQ.pop_front();
            assertCount++;
            if (busA.rd_data[31:0] !== ex.data[31:0] || busA.rd_busy[0] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busA.rd_data[31:0], busA.rd_busy[0], ex.data[31:0], ex.busy);
            end
            ex = expQ.pop_front();
            assertCount++;
            if (busB.rd_data[31:0] !== ex.data[31:0] || busB.rd_busy[0] !== ex.busy) begin
                failCount++;
                $display("[TB] FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         ex.tag, busB.rd_data[31:0], busB.rd_busy[0], ex.data[31:0], ex.busy);
            end
        end
    endtask

    // Random traffic on the 64-bit / 16-register / 3-read / 1-write instance
    // against a reference model of array, busy bits and bypass.
    task automatic test_param_sweep();
        logic [63:0] modelMem [16];
        logic [15:0] modelBusy;
        logic [3:0]  rdA [3];
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic        we;
        logic        re;
        logic [63:0] wd;
        for (int i = 0; i < 16; i++) modelMem[i] = '0;
        modelBusy = '0;
        repeat (300) begin
            @(negedge clk);
            driveIdle();
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            re = ($urandom_range(0, 2) == 0);
            ra = 4'($urandom_range(0, 15));
            busC.wr_en[0] = we; busC.wr_addr = wa; busC.wr_data = wd;
            busC.rsv_en = re; busC.rsv_addr = ra;
            for (int k = 0; k < 3; k++) begin
                rdA[k] = 4'($urandom_range(0, 15));
                busC.rd_addr[k*4 +: 4] = rdA[k];
                if (rdA[k] == 4'd0)
                    expQ.push_back('{64'h0, 1'b0, "sweep_x0"});
                else if (we && wa == rdA[k])
                    expQ.push_back('{wd, 1'b0, "sweep_bypass"});
                else
                    expQ.push_back('{modelMem[rdA[k]], modelBusy[rdA[k]], "sweep_stored"});
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                ex = expQ.pop_front();
                assertCount++;
                if (busC.rd_data[k*64 +: 64] !== ex.data || busC.rd_busy[k] !== ex.busy) begin
                    failCount++;
                    $display("[TB] FAIL %s port%0d addr=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                             ex.tag, k, rdA[k], busC.rd_data[k*64 +: 64], busC.rd_busy[k], ex.data, ex.busy);
                end
            end
            if (we && wa != 4'd0) begin
                modelMem[wa]  = wd;
                modelBusy[wa] = 1'b0;
            end
            if (re && ra != 4'd0) modelBusy[ra] = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the single-write, two-read integer register bank.
- Multi-port register file: NRD combinational read ports, NWR write (writeback) ports, optional write-to-read bypass, per-register busy scoreboard with a reserve port.
- Sits between decode/issue (reads, reservations) and the writeback stage(s).
- Register 0 is hardwired zero and is never busy.

Parameters:
- XLEN, 32, data width of every register.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered state only.
- AW, $clog2(NREG), address width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- rd_busy  out  NRD  1 = register for port k has a reserved write still outstanding
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- rsv_en  in  1  reserve a destination register (issue of a writing instruction)
- rsv_addr  in  AW  register to reserve

Behaviour:
- Reset: while rst_n = 0, asynchronously clear all registers to 0 and all busy bits to 0.
  - rd_data follows the cleared array, so it reads 0 for every address.
  - rd_busy reads 0.
  - Reset asserted mid-operation discards any in-flight write or reservation. No write takes effect on the edge where rst_n is low.
- Write: on posedge clk, each port j with wr_en[j] = 1 and wr_addr[j] != 0 stores wr_data[j].
  - Writes to address 0 are ignored.
  - Two ports writing the same address in the same cycle: the highest-index port wins.
  - A write with wr_en = 1 clears the busy bit of its address.
- Reserve: on posedge clk, rsv_en = 1 with rsv_addr != 0 sets busy[rsv_addr]. rsv_addr = 0 is ignored.
  - If a reserve and a write to the same address occur in the same cycle, the reserve wins and busy stays 1. The write data is still stored.
- Read (combinational, zero latency):
  - rd_addr = 0 always returns 0 with busy 0.
  - BYPASS = 1: if any wr_en[j] is set with wr_addr[j] equal to rd_addr[k] (nonzero), return the highest-index matching wr_data[j] and force rd_busy[k] to 0. Otherwise return the stored value and the registered busy bit.
  - BYPASS = 0: return the stored value and the registered busy bit. A same-cycle write becomes visible on the next cycle.
  - A same-cycle reservation is never visible on rd_busy until the following cycle.
- No backpressure. All ports may be active in every cycle.
- Address values of NREG or above cannot occur because NREG is a power of two.

Decomposition:
- Package regfile_pkg: a clog2-style address-width helper function and a constant for the zero-register index.
- One natural sub-module: regfile_bypass_mux, instantiated once per read port.
  - Inputs: the read address, the stored value, the stored busy bit, and all write ports.
  - Outputs: rd_data and rd_busy for that port, applying the zero-register rule, the highest-index priority and the BYPASS generate selection.
- The storage array, busy vector and reset logic stay in regfile_mp.

Test Plan:
- Reset then read: drive rst_n low mid-run after writing x5 = 0xDEADBEEF, then read x5 -> 0x0 immediately (asynchronously) and rd_busy = 0.
- Write then read: write x3 = 0x12345678 on port 0; with BYPASS = 1 read x3 in the same cycle -> 0x12345678. With BYPASS = 0 the same-cycle read -> 0x0 and the next cycle -> 0x12345678.
- Same-address write collision: port 0 writes x7 = 0x1111, port 1 writes x7 = 0x2222 in the same cycle -> the next-cycle read of x7 = 0x2222, and the same-cycle bypass read also = 0x2222.
- Zero register: write x0 = 0xFFFFFFFF and reserve x0 -> read x0 = 0x0, rd_busy = 0.
- Scoreboard:
  - Reserve x9 -> next cycle rd_busy = 1.
  - Write x9 = 0xABCD -> same-cycle bypass read gives rd_busy = 0 and data 0xABCD; the next cycle gives busy = 0.
  - Reserve and write x9 in the same cycle -> the next cycle gives busy = 1 and data = the written value.
- Parameter sweep: NREG = 16, NRD = 3, NWR = 1, XLEN = 64 -> random write/read/reserve traffic matches a reference model on all three read ports.
